// File: rtl/usbf_dma_sched.sv
// Round-robin DMA scheduler for the 16 USB endpoint request lines: one word per grant,
// per-endpoint burst limit, completion watchdog, one-cycle acknowledge back to the endpoint.
module usbf_dma_sched #(
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [15:0] dma_req_i,
  output logic [15:0] dma_ack_o,
  output logic        xfer_req_o,
  output logic [3:0]  xfer_ep_o,
  input  logic        xfer_done_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [3:0]  err_ep_o
);

  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);
  localparam logic [7:0] LP_TIMEOUT   = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_ACK, S_GAP} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_req;
  logic [3:0]  r_ptr, r_cur, r_burst;
  logic [7:0]  r_wd;
  logic [15:0] r_ack;
  logic        r_xfer_req, r_busy, r_err;
  logic [3:0]  r_xfer_ep, r_err_ep;

  logic [3:0]  w_rot_ep, w_winner;
  logic        w_rot_hit, w_cont, w_grant, w_wd_expired;

  // Rotation search from ptr+1; i = 16 wraps back to ptr itself.
  always_comb begin
    w_rot_ep  = r_ptr;
    w_rot_hit = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (!w_rot_hit && r_req[r_ptr + 4'(i)]) begin
        w_rot_hit = 1'b1;
        w_rot_ep  = r_ptr + 4'(i);
      end
    end
  end

  assign w_cont       = r_req[r_cur] && (r_burst < LP_MAX_BURST);
  assign w_winner     = w_cont ? r_cur : w_rot_ep;
  assign w_grant      = enable_i && (|r_req);
  assign w_wd_expired = (r_wd == LP_TIMEOUT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_XFER;
      S_XFER: begin
        if (xfer_done_i)       w_state_nxt = S_ACK;
        else if (w_wd_expired) w_state_nxt = S_GAP;
      end
      S_ACK:   w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req      <= '0;
      r_ptr      <= 4'd15;
      r_cur      <= '0;
      r_burst    <= '0;
      r_wd       <= '0;
      r_ack      <= '0;
      r_xfer_req <= 1'b0;
      r_xfer_ep  <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_err_ep   <= '0;
    end else begin
      r_req      <= dma_req_i;
      r_ack      <= '0;
      r_err      <= 1'b0;
      r_xfer_req <= (w_state_nxt == S_XFER);
      r_busy     <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_ptr     <= w_winner;
            r_xfer_ep <= w_winner;
            r_wd      <= 8'd1;
            if (w_winner != r_cur) begin
              r_cur   <= w_winner;
              r_burst <= '0;
            end
          end
        end
        S_XFER: begin
          r_wd <= r_wd + 8'd1;
          if (xfer_done_i) begin
            r_ack <= 16'(1) << r_cur;
            if (r_burst != 4'hF) r_burst <= r_burst + 4'd1;
          end else if (w_wd_expired) begin
            r_err    <= 1'b1;
            r_err_ep <= r_xfer_ep;
            r_burst  <= LP_MAX_BURST;
          end
        end
        default: ;
      endcase
    end
  end

  assign dma_ack_o  = r_ack;
  assign xfer_req_o = r_xfer_req;
  assign xfer_ep_o  = r_xfer_ep;
  assign busy_o     = r_busy;
  assign err_o      = r_err;
  assign err_ep_o   = r_err_ep;

endmodule

// File: tb/tb_usbf_dma_sched.sv
// Directed bench for usbf_dma_sched: single request, burst rotation, wrap-around,
// watchdog abort, enable drop and asynchronous reset mid-transfer.
module tb_usbf_dma_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] req = '0;
  logic        done = 1'b0;
  logic [15:0] ack;
  logic        xreq, busy, err;
  logic [3:0]  xep, err_ep;

  int n_cmp  = 0;
  int n_fail = 0;

  usbf_dma_sched #(.MAX_BURST(4), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .dma_req_i(req),
    .dma_ack_o(ack), .xfer_req_o(xreq), .xfer_ep_o(xep), .xfer_done_i(done),
    .busy_o(busy), .err_o(err), .err_ep_o(err_ep)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed hang, required finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One word: wait for xfer_req, return done 2 cycles after it rises, check the ack.
  task automatic do_word(input string tag, input logic [3:0] exp_ep,
                         input bit drop_en, input int exp_wait);
    int w = 0;
    while (xreq !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    chk({tag, "_req"}, 32'(xreq), 32'd1);
    if (exp_wait >= 0) chk({tag, "_lat"}, w, exp_wait);
    chk({tag, "_ep"}, 32'(xep), 32'(exp_ep));
    if (drop_en) enable = 1'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk({tag, "_ack"}, 32'(ack), 32'(16'h1 << exp_ep));
    chk({tag, "_reqlow"}, 32'(xreq), 32'd0);
    tick();
    chk({tag, "_ackgap"}, 32'(ack), 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_xreq", 32'(xreq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_errep", 32'(err_ep), 32'd0);
    chk("rst_xep", 32'(xep), 32'd0);

    // Single steady request on ep3: 5-cycle word period, waits of 2 after the first
    req = 16'h0008;
    do_reset();
    do_word("single0", 4'd3, 1'b0, -1);
    do_word("single1", 4'd3, 1'b0, 2);
    do_word("single2", 4'd3, 1'b0, 2);

    // Burst rotation: ep2 x4, ep9 x4, ep2 x4
    req = 16'h0204;
    do_reset();
    for (int k = 0; k < 4; k++) do_word("burst_a", 4'd2, 1'b0, -1);
    for (int k = 0; k < 4; k++) do_word("burst_b", 4'd9, 1'b0, -1);
    for (int k = 0; k < 4; k++) do_word("burst_c", 4'd2, 1'b0, -1);

    // Wrap-around: ep14, then ep15 past the top, then ep1 after ep15 withdraws
    req = 16'h4000;
    do_reset();
    do_word("wrap14", 4'd14, 1'b0, -1);
    req = 16'h8002;
    do_word("wrap15", 4'd15, 1'b0, -1);
    req = 16'h0002;
    do_word("wrap1", 4'd1, 1'b0, -1);

    // Watchdog: ep5, no done, 8 XFER cycles then abort
    req = 16'h0020;
    do_reset();
    begin
      int w = 0;
      while (xreq !== 1'b1 && w < 50) begin
        tick();
        w++;
      end
    end
    chk("wd_req", 32'(xreq), 32'd1);
    chk("wd_ep", 32'(xep), 32'd5);
    for (int k = 0; k < 7; k++) tick();
    chk("wd_req_8th", 32'(xreq), 32'd1);
    chk("wd_err_early", 32'(err), 32'd0);
    tick();
    chk("wd_err", 32'(err), 32'd1);
    chk("wd_errep", 32'(err_ep), 32'd5);
    chk("wd_reqdrop", 32'(xreq), 32'd0);
    chk("wd_noack", 32'(ack), 32'd0);
    chk("wd_busy_gap", 32'(busy), 32'd1);
    req = 16'h0021;
    tick();
    chk("wd_err_pulse", 32'(err), 32'd0);
    chk("wd_errep_hold", 32'(err_ep), 32'd5);
    do_word("wd_rotate", 4'd0, 1'b0, -1);

    // Enable drop mid-XFER: word completes, then nothing until enable returns
    req = 16'h0010;
    enable = 1'b1;
    do_reset();
    do_word("en_drop", 4'd4, 1'b1, -1);
    begin
      int seen = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (xreq === 1'b1) seen++;
      end
      chk("en_hold_noreq", seen, 0);
    end
    chk("en_hold_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    begin
      int w = 0;
      while (xreq !== 1'b1 && w < 50) begin
        tick();
        w++;
      end
    end
    chk("en_resume_req", 32'(xreq), 32'd1);
    chk("en_resume_ep", 32'(xep), 32'd4);
    chk("en_resume_busy", 32'(busy), 32'd1);

    // Asynchronous reset mid-XFER, between clock edges
    #3;
    rst = 1'b1;
    #1;
    chk("arst_xreq", 32'(xreq), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    req = 16'hFFFF;
    tick();
    rst = 1'b0;
    do_word("arst_first", 4'd0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
